baud_tick_gen: RTL and testbench

Next-generation UART timing source, replacing the fixed integer prescaler.
- Produces an oversample tick, a mid-bit sample tick, a bit tick and a legacy square-wave `clk_div` from one source clock.
- The divisor is fractional (integer plus fraction) and runtime-loadable through a shadow register that applies at a period boundary.
- A `resync` input re-aligns the phase for UART RX start-bit detection.
- Sits between the `config.v` clock constants and the UART TX/RX engines.

---
 rtl/baud_tick_gen_pkg.sv | 32 +++
 rtl/baud_tick_gen_frac_accum.sv | 53 +++++
 rtl/baud_tick_gen.sv | 158 +++++++++++++++
 tb/tb_baud_tick_gen.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/baud_tick_gen_pkg.sv
// Shared clock constants for the UART timing source: source clock, baud rate,
// oversample ratio and the reset-time divisor derived from them.
package baud_tick_gen_pkg;

    localparam int unsigned SOURCE_CLK     = 32'd50_000_000;
    localparam int unsigned BAUD_RATE      = 32'd9600;
    localparam int unsigned OVERSAMPLE_DEF = 32'd16;
    localparam int unsigned CNT_W_DEF      = 32'd16;
    localparam int unsigned FRAC_W_DEF     = 32'd4;

    // Integer part of clk / (baud * oversample).
    function automatic int unsigned calc_div_int(input int unsigned clk_hz,
                                                 input int unsigned baud,
                                                 input int unsigned os);
        return clk_hz / (baud * os);
    endfunction

    // Fractional remainder of clk / (baud * oversample), scaled by 2^frac_w.
    function automatic int unsigned calc_div_frac(input int unsigned clk_hz,
                                                  input int unsigned baud,
                                                  input int unsigned os,
                                                  input int unsigned frac_w);
        int unsigned scaled;
        scaled = (clk_hz << frac_w) / (baud * os);
        return scaled - (calc_div_int(clk_hz, baud, os) << frac_w);
    endfunction

    // 50 MHz / (9600 * 16) = 325.52 -> 325 + 8/16
    localparam int unsigned DEFAULT_INT_DEF  = calc_div_int(SOURCE_CLK, BAUD_RATE, OVERSAMPLE_DEF);
    localparam int unsigned DEFAULT_FRAC_DEF = calc_div_frac(SOURCE_CLK, BAUD_RATE, OVERSAMPLE_DEF, FRAC_W_DEF);

endpackage

// File: rtl/baud_tick_gen_frac_accum.sv
// Fractional divisor accumulator. On every oversample boundary the fraction
// is added to the accumulator; an overflow stretches the next period by one
// source clock.
module frac_accum
    import baud_tick_gen_pkg::*;
#(
    parameter int unsigned FRAC_W = FRAC_W_DEF
) (
    input  logic              src_clk,
    input  logic              rst,
    input  logic              step,
    input  logic [FRAC_W-1:0] frac,
    input  logic              clr,
    output logic              extend
);

    logic [FRAC_W-1:0] acc_q;
    logic [FRAC_W-1:0] acc_d;
    logic              extend_q;
    logic              extend_d;
    logic [FRAC_W:0]   sum_s;

    assign sum_s  = {1'b0, acc_q} + {1'b0, frac};
    assign extend = extend_q;

    // Next-state: clear wins, a step folds in the fraction, otherwise hold.
    always_comb begin
        acc_d    = acc_q;
        extend_d = extend_q;
        if (clr) begin
            acc_d    = {FRAC_W{1'b0}};
            extend_d = 1'b0;
        end else if (step) begin
            acc_d    = sum_s[FRAC_W-1:0];
            extend_d = sum_s[FRAC_W];
        end else begin
            acc_d    = acc_q;
            extend_d = extend_q;
        end
    end

    // Accumulator and carry registers.
    always_ff @(posedge src_clk or posedge rst) begin
        if (rst) begin
            acc_q    <= {FRAC_W{1'b0}};
            extend_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            extend_q <= extend_d;
        end
    end

endmodule

// File: rtl/baud_tick_gen.sv
// Fractional-N UART baud tick generator: oversample, mid-bit and end-of-bit
// ticks plus a bit-rate square wave, with a shadowed runtime divisor that is
// applied at period boundaries, while idle, or on resync.
module baud_tick_gen
    import baud_tick_gen_pkg::*;
#(
    parameter int unsigned CNT_W        = CNT_W_DEF,
    parameter int unsigned FRAC_W       = FRAC_W_DEF,
    parameter int unsigned OVERSAMPLE   = OVERSAMPLE_DEF,
    parameter int unsigned DEFAULT_INT  = DEFAULT_INT_DEF,
    parameter int unsigned DEFAULT_FRAC = DEFAULT_FRAC_DEF
) (
    input  logic                          src_clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          resync,
    input  logic [CNT_W-1:0]              div_int,
    input  logic [FRAC_W-1:0]             div_frac,
    input  logic                          div_load,
    output logic                          div_pending,
    output logic                          os_tick,
    output logic                          mid_tick,
    output logic                          bit_tick,
    output logic [$clog2(OVERSAMPLE)-1:0] os_phase,
    output logic                          clk_div
);

    localparam int unsigned PH_W = $clog2(OVERSAMPLE);
    localparam logic [PH_W-1:0]   MID_PH   = PH_W'(OVERSAMPLE / 2 - 1);
    localparam logic [PH_W-1:0]   HALF_PH  = PH_W'(OVERSAMPLE / 2);
    localparam logic [PH_W-1:0]   LAST_PH  = PH_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0]  RST_INT  = CNT_W'(DEFAULT_INT);
    localparam logic [FRAC_W-1:0] RST_FRAC = FRAC_W'(DEFAULT_FRAC);

    logic [CNT_W-1:0]  cnt_q,         cnt_d;
    logic [PH_W-1:0]   phase_q,       phase_d;
    logic              clk_div_q,     clk_div_d;
    logic [CNT_W-1:0]  active_int_q,  active_int_d;
    logic [FRAC_W-1:0] active_frac_q, active_frac_d;
    logic [CNT_W-1:0]  shadow_int_q,  shadow_int_d;
    logic [FRAC_W-1:0] shadow_frac_q, shadow_frac_d;
    logic              pending_q,     pending_d;

    logic              extend_s;
    logic [CNT_W:0]    n_eff_s;
    logic [CNT_W:0]    terminal_s;
    logic              at_term_s;
    logic              os_tick_s;
    logic              apply_s;

    // Divisors below 2 cannot form a period, so they clamp to 2.
    assign n_eff_s    = (active_int_q < CNT_W'(2)) ? (CNT_W + 1)'(2) : {1'b0, active_int_q};
    assign terminal_s = n_eff_s - (CNT_W + 1)'(1) + {{CNT_W{1'b0}}, extend_s};
    // '>=' rather than '==': a divisor shrunk while idle can leave the counter
    // past the new terminal; it then ends the period at once instead of
    // running through a full counter wrap.
    assign at_term_s  = ({1'b0, cnt_q} >= terminal_s);
    assign os_tick_s  = en & ~resync & at_term_s;
    assign apply_s    = os_tick_s | ~en | resync;

    assign os_tick     = os_tick_s;
    assign mid_tick    = os_tick_s & (phase_q == MID_PH);
    assign bit_tick    = os_tick_s & (phase_q == LAST_PH);
    assign os_phase    = phase_q;
    assign clk_div     = clk_div_q;
    assign div_pending = pending_q;

    frac_accum #(
        .FRAC_W (FRAC_W)
    ) u_frac_accum (
        .src_clk (src_clk),
        .rst     (rst),
        .step    (os_tick_s),
        .frac    (active_frac_q),
        .clr     (resync),
        .extend  (extend_s)
    );

    // Counter, oversample phase and square-wave next-state.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (resync) begin
            cnt_d   = {CNT_W{1'b0}};
            phase_d = {PH_W{1'b0}};
        end else if (en) begin
            if (at_term_s) begin
                cnt_d   = {CNT_W{1'b0}};
                phase_d = (phase_q == LAST_PH) ? {PH_W{1'b0}} : phase_q + PH_W'(1);
            end else begin
                cnt_d   = cnt_q + CNT_W'(1);
                phase_d = phase_q;
            end
        end else begin
            cnt_d   = cnt_q;
            phase_d = phase_q;
        end
        // Low for the first half of each bit, high for the second half.
        clk_div_d = (phase_d >= HALF_PH);
    end

    // Shadow/active divisor next-state; an apply in the same cycle as a load
    // takes the old shadow and keeps the new value pending.
    always_comb begin
        active_int_d  = active_int_q;
        active_frac_d = active_frac_q;
        shadow_int_d  = shadow_int_q;
        shadow_frac_d = shadow_frac_q;
        pending_d     = pending_q;
        if (apply_s) begin
            active_int_d  = shadow_int_q;
            active_frac_d = shadow_frac_q;
        end else begin
            active_int_d  = active_int_q;
            active_frac_d = active_frac_q;
        end
        if (div_load) begin
            shadow_int_d  = div_int;
            shadow_frac_d = div_frac;
            pending_d     = 1'b1;
        end else if (apply_s) begin
            pending_d     = 1'b0;
        end else begin
            pending_d     = pending_q;
        end
    end

    // Timing state registers.
    always_ff @(posedge src_clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= {CNT_W{1'b0}};
            phase_q   <= {PH_W{1'b0}};
            clk_div_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            phase_q   <= phase_d;
            clk_div_q <= clk_div_d;
        end
    end

    // Divisor registers; reset restores the default divisor in both copies.
    always_ff @(posedge src_clk or posedge rst) begin
        if (rst) begin
            active_int_q  <= RST_INT;
            active_frac_q <= RST_FRAC;
            shadow_int_q  <= RST_INT;
            shadow_frac_q <= RST_FRAC;
            pending_q     <= 1'b0;
        end else begin
            active_int_q  <= active_int_d;
            active_frac_q <= active_frac_d;
            shadow_int_q  <= shadow_int_d;
            shadow_frac_q <= shadow_frac_d;
            pending_q     <= pending_d;
        end
    end

endmodule

// File: tb/tb_baud_tick_gen.sv
// Self-checking bench for baud_tick_gen (OVERSAMPLE=4): behavioural model
// compared every cycle, a table of divisor/period vectors, hand-written
// corner sequences and a randomized run.
module tb_baud_tick_gen;

    localparam int OS       = 4;
    localparam int FW       = 4;
    localparam int DEF_INT  = 325;
    localparam int DEF_FRAC = 8;

    logic        src_clk = 1'b0;
    logic        rst, en, resync, div_load;
    logic [15:0] div_int;
    logic [3:0]  div_frac;
    logic        div_pending, os_tick, mid_tick, bit_tick, clk_div;
    logic [1:0]  os_phase;

    baud_tick_gen #(
        .CNT_W(16), .FRAC_W(FW), .OVERSAMPLE(OS),
        .DEFAULT_INT(DEF_INT), .DEFAULT_FRAC(DEF_FRAC)
    ) dut (
        .src_clk(src_clk), .rst(rst), .en(en), .resync(resync),
        .div_int(div_int), .div_frac(div_frac), .div_load(div_load),
        .div_pending(div_pending), .os_tick(os_tick), .mid_tick(mid_tick),
        .bit_tick(bit_tick), .os_phase(os_phase), .clk_div(clk_div)
    );

    always #5 src_clk = ~src_clk;

    int checks   = 0;
    int failures = 0;

    // Model: divisors, fraction total, cycles elapsed in period, ticks seen.
    int m_ai, m_af, m_si, m_sf, m_pend, m_acc, m_ext, m_el, m_ph, m_clk;
    int last_tick, last_mid, last_bit, last_phase, last_pend, last_clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void m_reset();
        m_ai = DEF_INT; m_af = DEF_FRAC; m_si = DEF_INT; m_sf = DEF_FRAC;
        m_pend = 0; m_acc = 0; m_ext = 0; m_el = 0; m_ph = 0; m_clk = 0;
    endfunction

    function automatic int m_len();
        return ((m_ai < 2) ? 2 : m_ai) + m_ext;
    endfunction

    function automatic int m_tick();
        return (!rst && en && !resync && (m_el >= m_len() - 1)) ? 1 : 0;
    endfunction

    function automatic void m_step(input int t);
        int apply;
        int sum;
        apply = (t || !en || resync) ? 1 : 0;
        if (resync) begin
            m_el = 0; m_acc = 0; m_ext = 0; m_ph = 0;
        end else if (en) begin
            if (t) begin
                sum   = m_acc + m_af;
                m_ext = (sum >= (1 << FW)) ? 1 : 0;
                m_acc = sum % (1 << FW);
                m_el  = 0;
                m_ph  = (m_ph + 1) % OS;
            end else begin
                m_el++;
            end
        end
        m_clk = (m_ph >= OS / 2) ? 1 : 0;
        if (apply) begin
            m_ai = m_si; m_af = m_sf;
        end
        if (div_load) begin
            m_si = div_int; m_sf = div_frac; m_pend = 1;
        end else if (apply) begin
            m_pend = 0;
        end
    endfunction

    // One clock: compare just after the inputs settle, advance model at edge.
    task automatic cycle();
        int t;
        #1;
        t = m_tick();
        chk("os_tick",     os_tick,     t);
        chk("mid_tick",    mid_tick,    (t && m_ph == OS / 2 - 1) ? 1 : 0);
        chk("bit_tick",    bit_tick,    (t && m_ph == OS - 1) ? 1 : 0);
        chk("os_phase",    os_phase,    m_ph);
        chk("clk_div",     clk_div,     m_clk);
        chk("div_pending", div_pending, m_pend);
        last_tick = os_tick; last_mid = mid_tick; last_bit = bit_tick;
        last_phase = os_phase; last_pend = div_pending; last_clk = clk_div;
        @(posedge src_clk);
        if (!rst) m_step(t);
        @(negedge src_clk);
    endtask

    // Cycles up to and including the next os_tick (bounded).
    task automatic measure(output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!last_tick && n < 1000);
    endtask

    // Load a divisor while idle, clear the phase, then start counting.
    task automatic configure(input int i, input int f);
        en = 1'b0; resync = 1'b0;
        div_int = 16'(i); div_frac = 4'(f); div_load = 1'b1;
        cycle();
        div_load = 1'b0; resync = 1'b1;
        cycle();
        resync = 1'b0; en = 1'b1;
    endtask

    typedef struct {
        int dint;
        int dfrac;
        int p0, p1, p2, p3;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int n, total, ticks, first_os, first_mid, first_bit, hi;

        vecs[0] = '{4, 0,  4, 4, 4, 4};
        vecs[1] = '{4, 8,  4, 4, 5, 4};
        vecs[2] = '{0, 0,  2, 2, 2, 2};
        vecs[3] = '{1, 0,  2, 2, 2, 2};
        vecs[4] = '{5, 12, 5, 5, 6, 6};
        vecs[5] = '{2, 15, 2, 2, 3, 3};

        rst = 1'b1; en = 1'b0; resync = 1'b0; div_load = 1'b0;
        div_int = 16'd0; div_frac = 4'd0;
        m_reset();
        @(negedge src_clk);
        cycle();
        cycle();
        rst = 1'b0;

        // Default divisor after reset: first period is 325 cycles.
        en = 1'b1;
        measure(n);
        chk("default_period", n, DEF_INT);

        // Table of divisors and their first four periods.
        for (int v = 0; v < 6; v++) begin
            configure(vecs[v].dint, vecs[v].dfrac);
            measure(n); chk("vec_p0", n, vecs[v].p0);
            measure(n); chk("vec_p1", n, vecs[v].p1);
            measure(n); chk("vec_p2", n, vecs[v].p2);
            measure(n); chk("vec_p3", n, vecs[v].p3);
        end

        // Integer divisor 4: tick/mid/bit positions and square-wave duty.
        configure(4, 0);
        first_os = -1; first_mid = -1; first_bit = -1; hi = 0;
        for (int c = 0; c < 32; c++) begin
            cycle();
            if (last_tick && first_os < 0) first_os = c;
            if (last_mid && first_mid < 0) first_mid = c;
            if (last_bit && first_bit < 0) first_bit = c;
            hi += last_clk;
        end
        chk("int_first_os", first_os, 3);
        chk("int_first_mid", first_mid, 7);
        chk("int_first_bit", first_bit, 15);
        chk("int_clk_high", hi, 16);

        // 4 + 8/16: sixteen steady-state periods span 72 cycles.
        configure(4, 8);
        measure(n);
        total = 0;
        for (int k = 0; k < 16; k++) begin
            measure(n);
            total += n;
        end
        chk("frac_span16", total, 72);

        // Load while running; second load while pending wins.
        configure(4, 0);
        measure(n);
        cycle();
        div_int = 16'd9; div_frac = 4'd0; div_load = 1'b1;
        cycle();
        div_int = 16'd6;
        cycle();
        chk("load_pending", last_pend, 1);
        div_load = 1'b0;
        cycle();
        chk("load_old_period_tick", last_tick, 1);
        measure(n); chk("load_new_period", n, 6);
        chk("load_pending_clear", last_pend, 0);
        measure(n); chk("load_new_period2", n, 6);

        // Resync on what would be a tick cycle.
        configure(4, 0);
        measure(n);
        cycle(); cycle(); cycle();
        resync = 1'b1;
        cycle();
        chk("resync_no_tick", last_tick, 0);
        resync = 1'b0;
        measure(n);
        chk("resync_period", n, 4);
        chk("resync_phase", last_phase, 0);

        // Enable low for 10 cycles freezes the period.
        measure(n);
        cycle(); cycle();
        en = 1'b0; ticks = 0;
        for (int c = 0; c < 10; c++) begin
            cycle();
            ticks += last_tick;
        end
        chk("freeze_ticks", ticks, 0);
        en = 1'b1;
        measure(n);
        chk("freeze_resume", n, 2);

        // Clamp and reset mid-period with a pending load.
        configure(0, 0);
        measure(n); chk("clamp_period", n, 2);
        cycle();
        div_int = 16'd5; div_load = 1'b1;
        cycle();
        div_load = 1'b0;
        rst = 1'b1;
        m_reset();
        cycle();
        chk("rst_pending", last_pend, 0);
        chk("rst_tick", last_tick, 0);
        chk("rst_phase", last_phase, 0);
        cycle();
        rst = 1'b0;
        measure(n);
        chk("rst_default_period", n, DEF_INT);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            en       = ($urandom_range(0, 99) < 85);
            resync   = ($urandom_range(0, 99) < 3);
            div_load = ($urandom_range(0, 99) < 6);
            div_int  = 16'($urandom_range(0, 6));
            div_frac = 4'($urandom_range(0, 15));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
